// File: rtl/subneg_prog_loader.sv
// rtl/subneg_prog_loader.sv - byte-serial framed program loader for the SUBNEG core memory
module subneg_prog_loader #(
  parameter int          MEM_DEPTH = 22,
  parameter int          ADDR_W    = 5,
  parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_strobe,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              cpu_run,
  output logic              load_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [7:0]        LEN_MAX  = 8'(MEM_DEPTH);

  state_t            r_state, w_next_state;
  logic              r_sync1, r_sync2, r_sync_d;
  logic [ADDR_W-1:0] r_len, w_next_len;
  logic [ADDR_W-1:0] r_addr, w_next_addr;
  logic [7:0]        r_sum, w_next_sum;
  logic              r_wr_en, w_next_wr_en;
  logic [ADDR_W-1:0] r_wr_addr, w_next_wr_addr;
  logic [7:0]        r_wr_data, w_next_wr_data;
  logic              r_cpu_run, w_next_run;
  logic              r_load_err, w_next_err;
  logic              r_busy, w_next_busy;
  logic              w_evt;
  logic              w_hdr;
  logic [7:0]        w_sum_add;

  // One event per synchronized rising edge of the host strobe
  assign w_evt     = r_sync2 & ~r_sync_d;
  assign w_hdr     = (in_data == HDR_BYTE);
  assign w_sum_add = r_sum + in_data;

  always_comb begin
    w_next_state   = r_state;
    w_next_len     = r_len;
    w_next_addr    = r_addr;
    w_next_sum     = r_sum;
    w_next_wr_en   = 1'b0;
    w_next_wr_addr = r_wr_addr;
    w_next_wr_data = r_wr_data;
    w_next_run     = r_cpu_run;
    w_next_err     = r_load_err;
    if (w_evt) begin
      case (r_state)
        S_IDLE: if (w_hdr) begin
          w_next_state = S_LEN;
          w_next_err   = 1'b0;
          w_next_run   = 1'b0;
        end
        S_LEN: if (in_data >= 8'd1 && in_data <= LEN_MAX) begin
          w_next_state = S_DATA;
          w_next_len   = in_data[ADDR_W-1:0];
          w_next_addr  = '0;
          w_next_sum   = '0;
        end else begin
          w_next_state = S_ERR;
          w_next_err   = 1'b1;
          w_next_run   = 1'b0;
        end
        S_DATA: begin
          w_next_wr_en   = 1'b1;
          w_next_wr_addr = r_addr;
          w_next_wr_data = in_data;
          w_next_sum     = w_sum_add;
          if (r_addr == r_len - ADDR_ONE) w_next_state = S_CSUM;
          else                            w_next_addr  = r_addr + ADDR_ONE;
        end
        S_CSUM: if (w_sum_add == 8'd0) begin
          w_next_state = S_RUN;
          w_next_run   = 1'b1;
        end else begin
          w_next_state = S_ERR;
          w_next_err   = 1'b1;
          w_next_run   = 1'b0;
        end
        S_RUN: if (w_hdr) begin
          w_next_state = S_LEN;
          w_next_run   = 1'b0;
        end
        S_ERR: if (w_hdr) begin
          w_next_state = S_LEN;
          w_next_err   = 1'b0;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
    w_next_busy = (w_next_state == S_LEN) || (w_next_state == S_DATA) ||
                  (w_next_state == S_CSUM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_sync_d   <= 1'b0;
      r_len      <= '0;
      r_addr     <= '0;
      r_sum      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_cpu_run  <= 1'b0;
      r_load_err <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_sync1    <= in_strobe;
      r_sync2    <= r_sync1;
      r_sync_d   <= r_sync2;
      r_len      <= w_next_len;
      r_addr     <= w_next_addr;
      r_sum      <= w_next_sum;
      r_wr_en    <= w_next_wr_en;
      r_wr_addr  <= w_next_wr_addr;
      r_wr_data  <= w_next_wr_data;
      r_cpu_run  <= w_next_run;
      r_load_err <= w_next_err;
      r_busy     <= w_next_busy;
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign cpu_run  = r_cpu_run;
  assign load_err = r_load_err;
  assign busy     = r_busy;

endmodule

// File: tb/tb_subneg_prog_loader.sv
// tb/tb_subneg_prog_loader.sv - scoreboard bench for subneg_prog_loader
module tb_subneg_prog_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_strobe = 1'b0;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       cpu_run;
  logic       load_err;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise_cyc = -100;

  logic [4:0] exp_addr_q[$];
  logic [7:0] exp_data_q[$];

  subneg_prog_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_strobe(in_strobe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_run(cpu_run), .load_err(load_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Write pulse must appear three edges after the strobe rise: two sync flops plus the output register
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      checks++;
      if (exp_addr_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%02h cyc=%0d", wr_addr, wr_data, cyc);
      end else begin
        logic [4:0] ea;
        logic [7:0] ed;
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        if (wr_addr !== ea || wr_data !== ed) begin
          failures++;
          $display("FAIL write_value got addr=%0d data=%02h expected addr=%0d data=%02h",
                   wr_addr, wr_data, ea, ed);
        end
        checks++;
        if (cyc !== rise_cyc + 3) begin
          failures++;
          $display("FAIL write_timing got cyc=%0d expected cyc=%0d", cyc, rise_cyc + 3);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hi = 4, input int dly = 5);
    @(posedge clk);
    #(dly);
    in_data   = b;
    in_strobe = 1'b1;
    rise_cyc  = cyc;
    repeat (hi) @(posedge clk);
    #(dly);
    in_strobe = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic push_write(input logic [4:0] a, input logic [7:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  task automatic check_status(input string name, input logic e_run, input logic e_err,
                              input logic e_busy);
    checks++;
    if (cpu_run !== e_run || load_err !== e_err || busy !== e_busy) begin
      failures++;
      $display("FAIL %s got run=%b err=%b busy=%b expected run=%b err=%b busy=%b",
               name, cpu_run, load_err, busy, e_run, e_err, e_busy);
    end
    checks++;
    if (exp_addr_q.size() != 0) begin
      failures++;
      $display("FAIL %s_pending_writes got %0d expected 0", name, exp_addr_q.size());
      exp_addr_q.delete();
      exp_data_q.delete();
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 8'd0) begin
      failures++;
      $display("FAIL reset_write_port got en=%b addr=%0d data=%02h expected 0 0 00",
               wr_en, wr_addr, wr_data);
    end
    check_status("reset_status", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_good_frame();
    send_byte(8'hA5);
    check_status("good_hdr_busy", 1'b0, 1'b0, 1'b1);
    send_byte(8'h03);
    push_write(5'd0, 8'h12); send_byte(8'h12);
    push_write(5'd1, 8'h34); send_byte(8'h34);
    push_write(5'd2, 8'h56); send_byte(8'h56);
    check_status("good_csum_wait", 1'b0, 1'b0, 1'b1);
    send_byte(8'h64);
    check_status("good_frame_run", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_bad_checksum();
    send_byte(8'hA5);
    send_byte(8'h02);
    push_write(5'd0, 8'h10); send_byte(8'h10);
    push_write(5'd1, 8'h20); send_byte(8'h20);
    send_byte(8'h00);
    check_status("bad_csum_err", 1'b0, 1'b1, 1'b0);
    send_byte(8'h77);
    check_status("err_ignores_byte", 1'b0, 1'b1, 1'b0);
    send_byte(8'hA5);
    check_status("err_hdr_clears", 1'b0, 1'b0, 1'b1);
    send_byte(8'h00);
    check_status("len_zero_err", 1'b0, 1'b1, 1'b0);
    send_byte(8'hA5);
    send_byte(8'h17);
    check_status("len_23_err", 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_full_length();
    logic [7:0] sum;
    logic [7:0] d;
    sum = 8'd0;
    send_byte(8'hA5);
    send_byte(8'h16);
    for (int i = 0; i < 22; i++) begin
      d = 8'(i * 7 + 3);
      sum = sum + d;
      push_write(5'(i), d);
      send_byte(d);
    end
    check_status("full_len_csum_wait", 1'b0, 1'b0, 1'b1);
    send_byte(8'd0 - sum);
    check_status("full_len_run", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reload();
    send_byte(8'h55);
    check_status("run_ignores_byte", 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #5 in_data = 8'hA5; in_strobe = 1'b1; rise_cyc = cyc;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cpu_run !== 1'b1) begin
      failures++;
      $display("FAIL reload_before_event got run=%b expected 1", cpu_run);
    end
    @(posedge clk);
    #1;
    checks++;
    if (cpu_run !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reload_run_drop got run=%b busy=%b expected run=0 busy=1", cpu_run, busy);
    end
    repeat (2) @(posedge clk);
    #5 in_strobe = 1'b0;
    repeat (4) @(posedge clk);
    send_byte(8'h01);
    push_write(5'd0, 8'hFF); send_byte(8'hFF);
    send_byte(8'h01);
    check_status("reload_run", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset_mid_data();
    send_byte(8'hA5);
    send_byte(8'h03);
    push_write(5'd0, 8'h12); send_byte(8'h12);
    #3 reset = 1'b1;
    #1;
    checks++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 8'd0 || cpu_run !== 1'b0 ||
        load_err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_outputs got en=%b addr=%0d data=%02h run=%b err=%b busy=%b expected all 0",
               wr_en, wr_addr, wr_data, cpu_run, load_err, busy);
    end
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    send_byte(8'h34);
    check_status("post_reset_ignore", 1'b0, 1'b0, 1'b0);
    send_byte(8'hA5);
    send_byte(8'h03);
    push_write(5'd0, 8'h12); send_byte(8'h12);
    push_write(5'd1, 8'h34); send_byte(8'h34);
    push_write(5'd2, 8'h56); send_byte(8'h56);
    send_byte(8'h64);
    check_status("post_reset_frame", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_strobe_robustness();
    send_byte(8'hA5, 20, 5);
    check_status("long_strobe_hdr", 1'b0, 1'b0, 1'b1);
    send_byte(8'h02, 3, 3);
    push_write(5'd0, 8'h80); send_byte(8'h80, 20, 2);
    push_write(5'd1, 8'h7F); send_byte(8'h7F, 5, 7);
    send_byte(8'h01, 3, 1);
    check_status("strobe_robust_run", 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_full_length();
    test_reload();
    test_async_reset_mid_data();
    test_strobe_robustness();
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/subneg_prog_loader.md
Name: subneg_prog_loader

Overview:
- Upstream stage of the SUBNEG core: a byte-serial program loader that receives a framed memory image from the dedicated input pins and writes it into the core's 22-byte unified memory through a write port.
- Releases the core with cpu_run only after a complete frame with a valid checksum.
- Lets the host replace the program without the fixed reset-time image.

Parameters:
- MEM_DEPTH, 22, number of memory bytes; legal frame length is 1..MEM_DEPTH.
- ADDR_W, 5, width of the write address.
- HDR_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- in_data  input  8  byte from host pins; must be stable while in_strobe is high
- in_strobe  input  1  host byte strobe; asynchronous to clk, one byte per rising edge
- wr_en  output  1  one-cycle memory write pulse to the core
- wr_addr  output  ADDR_W  memory address for wr_data
- wr_data  output  8  byte to write
- cpu_run  output  1  high when a valid image is loaded; the core executes only while high
- load_err  output  1  sticky frame-error flag
- busy  output  1  high while a frame is in progress (states LEN, DATA, CSUM)

Behaviour:
- Reset (async, active-high) clears all state and outputs to 0 and sets the state to IDLE, including mid-frame. Memory bytes already written are not undone.
- Strobe capture:
  - in_strobe passes through a 2-flop synchronizer plus an edge register.
  - A byte event fires in the cycle the synchronized strobe first reads 1 while the previous value was 0.
  - in_data is sampled in that cycle.
  - Host requirements: strobe high ≥3 clk, low ≥3 clk, data stable from strobe rise to strobe fall.
- All outputs are registered.
- State machine, advanced only on byte events (no event means hold state):
  - IDLE: byte==HDR_BYTE → LEN, clear load_err and cpu_run. Any other byte is ignored and the state stays IDLE.
  - LEN: len=byte. If 1≤len≤MEM_DEPTH → DATA, set addr=0 and sum=0. Otherwise → ERR.
  - DATA: write byte at addr; sum=sum+byte (mod 256); addr++. When addr reaches len-1 and that byte is written → CSUM.
  - CSUM: if (sum+byte) mod 256 == 0 → RUN. Otherwise → ERR.
  - RUN: cpu_run=1. A byte equal to HDR_BYTE drops cpu_run (next cycle) and goes to LEN. Other bytes are ignored.
  - ERR: load_err=1, cpu_run=0. Only HDR_BYTE leaves ERR (→ LEN, load_err cleared). Other bytes are ignored.
- Write timing:
  - For a DATA-state event in cycle k, wr_en=1 with wr_addr and wr_data valid in cycle k+1, for exactly one cycle.
  - In all other cycles wr_en=0; wr_addr and wr_data hold their last values.
- cpu_run rises the cycle after the CSUM event that passes. It falls the cycle after a header event in RUN, or on reset.
- busy is 1 exactly in LEN, DATA and CSUM.
- No timeout: a partial frame waits indefinitely until the next byte or reset.
- Strobe held high continuously produces one event only.
- The core must not write memory while cpu_run=0. Loader writes never overlap core execution.

Test Plan:
- Good frame: A5,03,12,34,56,64.
  - Expect three wr_en pulses (addr0=0x12, addr1=0x34, addr2=0x56), each one cycle after its event.
  - cpu_run=1 after the last byte; load_err=0; busy low.
- Bad checksum: A5,02,10,20,00.
  - Expect two writes, then load_err=1 and cpu_run=0.
  - A following byte 0x77 is ignored.
  - A5 clears load_err and busy=1.
- Length bounds:
  - A5,00 → ERR with no writes.
  - A5,17 (23) → ERR.
  - A5,16 (22) followed by 22 bytes plus the correct checksum → writes at addresses 0..21, then cpu_run=1.
- Reload while running: after a good frame, send A5.
  - cpu_run falls the next cycle.
  - A new 1-byte frame A5,01,FF,01 → write addr0=0xFF, cpu_run=1.
- Async reset asserted mid-DATA, between cycle edges:
  - All outputs are 0 immediately and the state is IDLE.
  - After release, a non-header byte is ignored and a full good frame loads correctly.
- Strobe robustness: strobe held high for 20 cycles, and a glitch-free strobe asserted mid-clock-period.
  - Exactly one event per rising edge; no double writes.
